regfile_mp: RTL and testbench

Parametrised multi-port register file for the datapath's decode/writeback stages: NRD combinational read ports, NWR write ports, and a hardwired-zero register 0. Writes commit on the rising clock edge with fixed port priority. A sequential clear engine zeroes the array one entry per cycle on request. Optional same-cycle write-to-read bypass is selectable at compile time.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_fsm.sv | 57 +++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and clear-FSM state type for regfile_mp.
// Optional bypass build macro: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_NREGS  = 32;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential sweep engine that zeroes one entry per cycle.
// Walks ptr from 1 to NREGS-1; entry 0 is hardwired and never swept.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter  int NREGS  = REGFILE_NREGS,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

    clr_state_t state;

    // State, pointer and registered busy flag advance together
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= FIRST;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= FIRST;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= FIRST;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + FIRST;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= FIRST;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we = busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, hardwired r0, sweep clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_W = REGFILE_DATA_W,
    parameter  int NREGS  = REGFILE_NREGS,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*ADDR_W-1:0] wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic [NRD*ADDR_W-1:0] rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_drop
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] ptr;
    logic              clr_we;

    regfile_clr_fsm #(
        .NREGS (NREGS)
    ) u_clr (
        .CLK     (CLK),
        .RST     (RST),
        .clr_req (clr_req),
        .busy    (busy),
        .ptr     (ptr),
        .clr_we  (clr_we)
    );

    // Array update: reset, sweep, or port writes where the last port wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[ptr] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && wsel[p*ADDR_W +: ADDR_W] != '0) begin
                    regs[wsel[p*ADDR_W +: ADDR_W]] <= wdat[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] val;

        assign sel = rsel[r*ADDR_W +: ADDR_W];

        // Stored value, forced to zero for r0 and during a sweep
        always_comb begin
            val = regs[sel];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && wsel[p*ADDR_W +: ADDR_W] == sel) begin
                    val = wdat[p*DATA_W +: DATA_W];
                end
            end
`endif
            if (busy || sel == '0) begin
                val = '0;
            end
        end

        assign rdat[r*DATA_W +: DATA_W] = val;
    end

    assign wr_drop = busy & (|wen);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench
// for two regfile_mp configurations.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_clr;
  logic        a_busy, a_drop;
  logic [1:0]  a_wen;
  logic [9:0]  a_wsel, a_rsel;
  logic [63:0] a_wdat, a_rdat;

  logic        b_rst, b_clr;
  logic        b_busy, b_drop;
  logic [0:0]  b_wen;
  logic [2:0]  b_wsel;
  logic [15:0] b_wdat;
  logic [8:0]  b_rsel;
  logic [47:0] b_rdat;

  regfile_mp u_a (
    .CLK     (clk),
    .RST     (a_rst),
    .wen     (a_wen),
    .wsel    (a_wsel),
    .wdat    (a_wdat),
    .rsel    (a_rsel),
    .rdat    (a_rdat),
    .clr_req (a_clr),
    .busy    (a_busy),
    .wr_drop (a_drop)
  );

  regfile_mp #(
    .DATA_W (16),
    .NREGS  (8),
    .NRD    (3),
    .NWR    (1)
  ) u_b (
    .CLK     (clk),
    .RST     (b_rst),
    .wen     (b_wen),
    .wsel    (b_wsel),
    .wdat    (b_wdat),
    .rsel    (b_rsel),
    .rdat    (b_rdat),
    .clr_req (b_clr),
    .busy    (b_busy),
    .wr_drop (b_drop)
  );

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [31:0] mem_a [32];
  logic [15:0] mem_b [8];
  int          a_bcnt = 0;
  int          b_bcnt = 0;

  function automatic void push(
    int k, int i,
    logic [31:0] e, string n
  );
    exp_t x;
    x.kind = k;
    x.idx  = i;
    x.exp  = e;
    x.name = n;
    sbq.push_back(x);
  endfunction

  task automatic chk(
    input logic [63:0] act,
    input logic [63:0] exp,
    input string       name
  );
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h exp %h at %0t",
                  name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0: act = a_rdat[e.idx*32 +: 32];
        1: act = {31'b0, a_busy};
        2: act = {31'b0, a_drop};
        3: act = {16'b0, b_rdat[e.idx*16 +: 16]};
        4: act = {31'b0, b_busy};
        default: act = {31'b0, b_drop};
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s got %h expected %h at %0t",
                    e.name, act, e.exp, $time);
    end
  end

  task automatic drive_a(
    input logic        rst,
    input logic        clr,
    input logic [1:0]  wen,
    input logic [4:0]  s0,
    input logic [4:0]  s1,
    input logic [31:0] d0,
    input logic [31:0] d1,
    input logic [4:0]  r0,
    input logic [4:0]  r1
  );
    logic [4:0]  sel;
    logic [31:0] val;
    bit          bsy;
    a_rst  = rst;
    a_clr  = clr;
    a_wen  = wen;
    a_wsel = {s1, s0};
    a_wdat = {d1, d0};
    a_rsel = {r1, r0};
    bsy = (a_bcnt > 0);
    for (int r = 0; r < 2; r++) begin
      sel = (r == 0) ? r0 : r1;
      val = (sel == 0) ? 32'h0 : mem_a[sel];
`ifdef REGFILE_BYPASS_EN
      if (sel != 0 && wen[0] && s0 == sel) val = d0;
      if (sel != 0 && wen[1] && s1 == sel) val = d1;
`endif
      if (bsy) val = 32'h0;
      push(0, r, val,
           $sformatf("a_rdat%0d_r%0d", r, sel));
    end
    push(1, 0, {31'b0, bsy}, "a_busy");
    push(2, 0, {31'b0, bsy && (wen != 0)},
         "a_wr_drop");
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (mem_a[i]) mem_a[i] = 32'h0;
      a_bcnt = 0;
    end else if (a_bcnt > 0) begin
      a_bcnt--;
    end else begin
      if (wen[0] && s0 != 0) mem_a[s0] = d0;
      if (wen[1] && s1 != 0) mem_a[s1] = d1;
      if (clr) begin
        foreach (mem_a[i]) mem_a[i] = 32'h0;
        a_bcnt = 31;
      end
    end
  endtask

  task automatic drive_b(
    input logic        rst,
    input logic        clr,
    input logic        wen,
    input logic [2:0]  s,
    input logic [15:0] d,
    input logic [2:0]  r0,
    input logic [2:0]  r1,
    input logic [2:0]  r2
  );
    logic [2:0]  sel;
    logic [15:0] val;
    bit          bsy;
    b_rst  = rst;
    b_clr  = clr;
    b_wen  = wen;
    b_wsel = s;
    b_wdat = d;
    b_rsel = {r2, r1, r0};
    bsy = (b_bcnt > 0);
    for (int r = 0; r < 3; r++) begin
      sel = (r == 0) ? r0 : (r == 1) ? r1 : r2;
      val = (sel == 0) ? 16'h0 : mem_b[sel];
`ifdef REGFILE_BYPASS_EN
      if (sel != 0 && wen && s == sel) val = d;
`endif
      if (bsy) val = 16'h0;
      push(3, r, {16'b0, val},
           $sformatf("b_rdat%0d_r%0d", r, sel));
    end
    push(4, 0, {31'b0, bsy}, "b_busy");
    push(5, 0, {31'b0, bsy && wen}, "b_wr_drop");
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (mem_b[i]) mem_b[i] = 16'h0;
      b_bcnt = 0;
    end else if (b_bcnt > 0) begin
      b_bcnt--;
    end else begin
      if (wen && s != 0) mem_b[s] = d;
      if (clr) begin
        foreach (mem_b[i]) mem_b[i] = 16'h0;
        b_bcnt = 7;
      end
    end
  endtask

  task automatic rand_a(input logic clr);
    drive_a(1'b0, clr, 2'($urandom_range(0, 3)),
            5'($urandom), 5'($urandom),
            $urandom, $urandom,
            5'($urandom), 5'($urandom));
  endtask

  initial begin
    foreach (mem_a[i]) mem_a[i] = 32'h0;
    foreach (mem_b[i]) mem_b[i] = 16'h0;
    a_rst = 1'b1; a_clr = 1'b0; a_wen = '0;
    a_wsel = '0; a_wdat = '0; a_rsel = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_wen = '0;
    b_wsel = '0; b_wdat = '0; b_rsel = '0;
    @(posedge clk);
    #1;
    chk({63'b0, a_busy}, 64'h0, "rst_a_busy");
    chk({63'b0, b_busy}, 64'h0, "rst_b_busy");
    chk(a_rdat, 64'h0, "rst_a_rdat");
    chk({16'b0, b_rdat}, 64'h0, "rst_b_rdat");
    b_rst = 1'b0;

    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 5'd5, 5'd31);
    drive_a(0, 0, 2'b01, 5'd5, 0, 32'hDEADBEEF, 0,
            5'd0, 5'd5);
    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 5'd5, 5'd5);
    drive_a(0, 0, 2'b11, 0, 0, 32'hFFFFFFFF,
            32'hFFFFFFFF, 0, 0);
    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0);
    drive_a(0, 0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22,
            5'd7, 5'd1);
    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 5'd7, 5'd7);

    for (int i = 1; i < 32; i++)
      drive_a(0, 0, 2'b01, 5'(i), 0, i, 0,
              5'(i - 1), 5'(i));
    drive_a(0, 1, 2'b00, 0, 0, 0, 0, 5'd3, 5'd30);
    for (int i = 0; i < 31; i++) rand_a(1'b1);
    chk({63'b0, a_busy}, 64'h0, "a_sweep_expired");
    for (int i = 0; i < 32; i += 2)
      drive_a(0, 0, 2'b00, 0, 0, 0, 0,
              5'(i), 5'(i + 1));

    for (int i = 1; i < 32; i++)
      drive_a(0, 0, 2'b10, 0, 5'(i), 0, 32'hA0 + i,
              5'(i), 5'(i));
    drive_a(0, 1, 2'b00, 0, 0, 0, 0, 5'd9, 5'd10);
    for (int i = 0; i < 9; i++) rand_a(1'b0);
    drive_a(1, 0, 2'b00, 0, 0, 0, 0, 5'd3, 5'd4);
    for (int i = 0; i < 32; i += 2)
      drive_a(0, 0, 2'b00, 0, 0, 0, 0,
              5'(i), 5'(i + 1));
    drive_a(0, 0, 2'b01, 5'd3, 0, 32'h3, 0,
            5'd3, 5'd0);
    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 5'd3, 5'd3);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        drive_a(1, 0, 2'b00, 0, 0, 0, 0,
                5'($urandom), 5'($urandom));
      else
        rand_a($urandom_range(0, 39) == 0);
    end
    drive_a(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    drive_b(0, 0, 1'b0, 0, 0, 3'd7, 3'd1, 3'd0);
    drive_b(0, 0, 1'b1, 3'd7, 16'hABCD,
            3'd7, 3'd7, 3'd0);
    drive_b(0, 0, 1'b0, 0, 0, 3'd7, 3'd7, 3'd7);
    for (int i = 1; i < 7; i++)
      drive_b(0, 0, 1'b1, 3'(i), 16'(i * 16'h111),
              3'(i), 3'd7, 3'(i - 1));
    drive_b(0, 1, 1'b0, 0, 0, 3'd7, 3'd2, 3'd1);
    for (int i = 0; i < 7; i++)
      drive_b(0, 0, 1'($urandom), 3'($urandom),
              16'($urandom), 3'(i), 3'd7, 3'd5);
    chk({63'b0, b_busy}, 64'h0, "b_sweep_expired");
    drive_b(0, 0, 1'($urandom), 3'($urandom),
            16'($urandom), 3'd7, 3'd7, 3'd5);
    for (int i = 0; i < 150; i++)
      drive_b($urandom_range(0, 79) == 0,
              $urandom_range(0, 19) == 0,
              1'($urandom), 3'($urandom),
              16'($urandom), 3'($urandom),
              3'($urandom), 3'($urandom));
    drive_b(0, 0, 1'b0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
